// File: rtl/hive_reg_xsr.sv
// hive_reg_xsr: per-thread periodic service-request generator on the register bus
module hive_reg_xsr #(
  parameter int THREADS     = 8,
  parameter int ALU_W       = 32,
  parameter int RBUS_ADDR_W = 8,
  parameter int BASE_ADDR   = 'h40,
  parameter int PER_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o,
  input  logic                   tick_i,
  output logic [THREADS-1:0]     xsr_o
);
  localparam logic [31:0] LO = 32'(BASE_ADDR);
  localparam logic [31:0] HI = 32'(BASE_ADDR + 8 + THREADS);
  logic [THREADS-1:0] en_q, en_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [THREADS-1:0] ev, per_wr, en_chg, pw1c, ow1c;
  logic [PER_W-1:0] per_q [THREADS];
  logic [PER_W-1:0] per_d [THREADS];
  logic [PER_W-1:0] cnt_q [THREADS];
  logic [PER_W-1:0] cnt_d [THREADS];
  logic [ALU_W-1:0] rd_q, rd_d;
  logic [31:0] addr, off;
  logic hit, wr, rd;
  logic [THREADS-1:0] wbits;
  logic [PER_W-1:0] wper;
  logic unused_wdata;
  assign unused_wdata = ^rbus_wr_data_i;
  // address decode and read mux; reads see pre-write register values
  always_comb begin
    addr = 32'(rbus_addr_i);
    off = addr - LO;
    hit = addr >= LO && addr < HI;
    wr = rbus_wr_i & hit;
    rd = rbus_rd_i & hit;
    wbits = rbus_wr_data_i[THREADS-1:0];
    wper = rbus_wr_data_i[PER_W-1:0];
    rd_d = !rd ? '0 : off == 32'd0 ? ALU_W'(en_q) : off == 32'd1 ? ALU_W'(pend_q) :
           off == 32'd2 ? ALU_W'(ovr_q) : '0;
    for (int t = 0; t < THREADS; t++)
      if (rd && off == 32'(8 + t)) rd_d = ALU_W'(per_q[t]);
  end
  // per-thread counters, events, pending and overrun bookkeeping
  always_comb begin
    en_d = (wr && off == 32'd0) ? wbits : en_q;
    for (int t = 0; t < THREADS; t++) begin
      per_wr[t] = wr && off == 32'(8 + t);
      en_chg[t] = en_d[t] != en_q[t];
      pw1c[t] = wr && off == 32'd1 && wbits[t];
      ow1c[t] = wr && off == 32'd2 && wbits[t];
      ev[t] = en_q[t] & tick_i & ~per_wr[t] & ~en_chg[t] & (cnt_q[t] == '0);
      per_d[t] = per_wr[t] ? wper : per_q[t];
      cnt_d[t] = per_wr[t] ? wper : en_chg[t] ? per_q[t] :
                 (en_q[t] & tick_i) ? ((cnt_q[t] == '0) ? per_q[t] : cnt_q[t] - PER_W'(1)) : cnt_q[t];
      pend_d[t] = (en_q[t] & ~en_d[t]) ? 1'b0 : ev[t] ? 1'b1 : pw1c[t] ? 1'b0 : pend_q[t];
      ovr_d[t] = (ev[t] & pend_q[t] & ~pw1c[t]) ? 1'b1 : ow1c[t] ? 1'b0 : ovr_q[t];
    end
  end
  // state registers with synchronous reset taking priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q <= '0;
      pend_q <= '0;
      ovr_q <= '0;
      rd_q <= '0;
      for (int t = 0; t < THREADS; t++) begin
        per_q[t] <= '0;
        cnt_q[t] <= '0;
      end
    end else begin
      en_q <= en_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      rd_q <= rd_d;
      for (int t = 0; t < THREADS; t++) begin
        per_q[t] <= per_d[t];
        cnt_q[t] <= cnt_d[t];
      end
    end
  end
  assign rbus_rd_data_o = rd_q;
  assign xsr_o = pend_q & en_q;
endmodule

// File: tb/tb_hive_reg_xsr.sv
// tb_hive_reg_xsr: scoreboard bench for hive_reg_xsr against a spec-level model
module tb_hive_reg_xsr;
  localparam int TH = 8;
  localparam int BASE = 'h40;
  localparam int PW = 16;
  logic clk = 0;
  logic rst_i = 0, rbus_wr_i = 0, rbus_rd_i = 0, tick_i = 0;
  logic [7:0] rbus_addr_i = 0;
  logic [31:0] rbus_wr_data_i = 0, rbus_rd_data_o;
  logic [TH-1:0] xsr_o;

  hive_reg_xsr #(.THREADS(TH), .ALU_W(32), .RBUS_ADDR_W(8), .BASE_ADDR(BASE), .PER_W(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .rbus_addr_i(rbus_addr_i), .rbus_wr_i(rbus_wr_i),
    .rbus_rd_i(rbus_rd_i), .rbus_wr_data_i(rbus_wr_data_i), .rbus_rd_data_o(rbus_rd_data_o),
    .tick_i(tick_i), .xsr_o(xsr_o));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rd; logic [TH-1:0] xsr;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;

  bit [TH-1:0] m_en, m_pend, m_ovr;
  int unsigned m_per[TH], m_cnt[TH];

  // monitor: outputs after each edge compared with the queued expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp += 2;
      if (rbus_rd_data_o !== e.rd) begin
        n_bad++;
        $display("FAIL rd_data: got %h expected %h at %0t", rbus_rd_data_o, e.rd, $time);
      end
      if (xsr_o !== e.xsr) begin
        n_bad++;
        $display("FAIL xsr: got %h expected %h at %0t", xsr_o, e.xsr, $time);
      end
    end
  end

  task automatic cyc(input int a, input bit w, input bit r, input logic [31:0] d, input bit t, input bit rs);
    int o;
    bit hit, en_new, ev, clr, oclr, pend_old;
    exp_t x;
    rbus_addr_i = a[7:0];
    rbus_wr_i = w;
    rbus_rd_i = r;
    rbus_wr_data_i = d;
    tick_i = t;
    rst_i = rs;
    o = a - BASE;
    hit = a >= BASE && a < BASE + 8 + TH;
    x.rd = 0;
    if (!rs && r && hit)
      x.rd = o == 0 ? 32'(m_en) : o == 1 ? 32'(m_pend) : o == 2 ? 32'(m_ovr) : o >= 8 ? m_per[o-8] : 0;
    if (rs) begin
      m_en = 0; m_pend = 0; m_ovr = 0;
      for (int i = 0; i < TH; i++) begin m_per[i] = 0; m_cnt[i] = 0; end
    end else begin
      for (int i = 0; i < TH; i++) begin
        en_new = (w && hit && o == 0) ? d[i] : m_en[i];
        clr = w && hit && o == 1 && d[i];
        oclr = w && hit && o == 2 && d[i];
        pend_old = m_pend[i];
        ev = 0;
        if (w && hit && o == 8 + i) begin
          m_cnt[i] = d & 32'hFFFF;
          m_per[i] = d & 32'hFFFF;
        end else if (en_new != m_en[i]) m_cnt[i] = m_per[i];
        else if (m_en[i] && t) begin
          if (m_cnt[i] == 0) begin ev = 1; m_cnt[i] = m_per[i]; end
          else m_cnt[i]--;
        end
        if (m_en[i] && !en_new) m_pend[i] = 0;
        else if (ev) m_pend[i] = 1;
        else if (clr) m_pend[i] = 0;
        if (ev && pend_old && !clr) m_ovr[i] = 1;
        else if (oclr) m_ovr[i] = 0;
        m_en[i] = en_new;
      end
    end
    x.xsr = m_pend & m_en;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d); cyc(a, 1, 0, d, 0, 0); endtask
  task automatic rd(input int a); cyc(a, 0, 1, 0, 0, 0); endtask
  task automatic tk(); cyc(0, 0, 0, 0, 1, 0); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic rst(); cyc(0, 0, 0, 0, 0, 1); endtask

  initial begin
    int a;
    logic [31:0] d;
    #1;
    rst(); rst();
    rd(BASE); rd(BASE + 1); rd(BASE + 2); rd(BASE + 8);
    // period 3 on thread 2: event on 4th tick, overrun on 8th
    wr(BASE + 10, 3); wr(BASE, 32'h04);
    repeat (8) begin tk(); idle(1); rd(BASE + 1); rd(BASE + 2); end
    // period 0: event each tick, serviced between ticks
    rst();
    wr(BASE + 8, 0); wr(BASE, 32'h01);
    repeat (4) begin tk(); idle(3); wr(BASE + 1, 32'h01); idle(5); rd(BASE + 2); end
    // W1C of a pending bit in the same cycle as a new event
    rst();
    wr(BASE + 13, 1); wr(BASE, 32'h20);
    tk(); tk(); idle(1); rd(BASE + 1);
    tk(); cyc(BASE + 1, 1, 0, 32'h20, 1, 0); rd(BASE + 1); rd(BASE + 2);
    // period write masking and reserved reads, read/write collision
    wr(BASE + 11, 32'h0001ABCD); rd(BASE + 11); rd(BASE + 5); wr(BASE + 5, 32'hFFFF);
    rd(BASE + 5); cyc(BASE + 11, 1, 1, 32'h1234, 0, 0); rd(BASE + 11);
    rd(BASE + 16); rd(BASE - 1); wr(BASE + 16, 1); wr(BASE - 1, 1);
    // all threads pending, then disable and reset mid-count
    for (int i = 0; i < TH; i++) wr(BASE + 8 + i, i);
    wr(BASE, 32'hFF);
    repeat (8) tk();
    rd(BASE + 1); wr(BASE, 0); rd(BASE + 1); rd(BASE + 2);
    wr(BASE, 32'hFF); tk(); tk(); rst();
    repeat (10) tk();
    rd(BASE); rd(BASE + 1); rd(BASE + 2); rd(BASE + 9);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 4) != 0) ? BASE + $urandom_range(0, 17) : $urandom_range(0, 255);
      d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 6);
      cyc(a, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, d,
          $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
    end
    idle(2);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
